// File: rtl/bp_mem_cmd_arbiter.sv
// bp_mem_cmd_arbiter
//
// Shares one backing-memory command/response port between num_req_p requesters.
// Commands are granted round-robin into a one-entry registered output stage. The
// winner's ID goes into an in-order tag FIFO. Each returning response pops that FIFO
// and is steered back to its originator through a one-entry response buffer.
//
// Ports:
//   clk_i            clock
//   reset_i          asynchronous active-high reset
//   req_cmd_i        per-requester command, requester i at slice i
//   req_cmd_v_i      per-requester command valid
//   req_cmd_ready_o  one-hot accept, high only for the granted requester
//   mem_cmd_o        registered command to memory
//   mem_cmd_v_o      command valid
//   mem_cmd_yumi_i   memory consumed mem_cmd_o
//   mem_resp_i       response from memory
//   mem_resp_v_i     response valid
//   mem_resp_ready_o arbiter can take a response this cycle
//   req_resp_o       buffered response, broadcast to all requesters
//   req_resp_v_o     one-hot valid to the owning requester
//   req_resp_yumi_i  requester consumed the response
//   outstanding_o    commands granted whose response has not yet been buffered

module bp_mem_cmd_arbiter #(
    parameter int unsigned num_req_p         = 2,
    parameter int unsigned mem_msg_width_p   = 128,
    parameter int unsigned max_outstanding_p = 4,
    parameter int unsigned req_id_width_p    = (num_req_p > 1) ? $clog2(num_req_p) : 1,
    localparam int unsigned cnt_width_lp     = $clog2(max_outstanding_p + 1)
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,

    input  logic [num_req_p*mem_msg_width_p-1:0] req_cmd_i,
    input  logic [num_req_p-1:0]                 req_cmd_v_i,
    output logic [num_req_p-1:0]                 req_cmd_ready_o,

    output logic [mem_msg_width_p-1:0]           mem_cmd_o,
    output logic                                 mem_cmd_v_o,
    input  logic                                 mem_cmd_yumi_i,

    input  logic [mem_msg_width_p-1:0]           mem_resp_i,
    input  logic                                 mem_resp_v_i,
    output logic                                 mem_resp_ready_o,

    output logic [mem_msg_width_p-1:0]           req_resp_o,
    output logic [num_req_p-1:0]                 req_resp_v_o,
    input  logic [num_req_p-1:0]                 req_resp_yumi_i,

    output logic [cnt_width_lp-1:0]              outstanding_o
);

    localparam int unsigned ptr_width_lp =
        (max_outstanding_p > 1) ? $clog2(max_outstanding_p) : 1;
    localparam logic [req_id_width_p-1:0] last_id_lp  = req_id_width_p'(num_req_p - 1);
    localparam logic [ptr_width_lp-1:0]   last_ptr_lp = ptr_width_lp'(max_outstanding_p - 1);
    localparam logic [cnt_width_lp-1:0]   max_cnt_lp  = cnt_width_lp'(max_outstanding_p);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                       cmd_v_r;
    logic [mem_msg_width_p-1:0] mem_cmd_r;
    logic [req_id_width_p-1:0]  rr_ptr_r;

    logic                       resp_v_r;
    logic [req_id_width_p-1:0]  resp_id_r;
    logic [mem_msg_width_p-1:0] resp_r;

    logic [req_id_width_p-1:0]  tag_mem_r [max_outstanding_p];
    logic [ptr_width_lp-1:0]    tag_rd_ptr_r;
    logic [ptr_width_lp-1:0]    tag_wr_ptr_r;
    logic [cnt_width_lp-1:0]    tag_cnt_r;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic [mem_msg_width_p-1:0] req_cmd_arr [num_req_p];
    logic                       tag_full;
    logic                       tag_empty;
    logic                       can_accept;
    logic                       grant_v;
    logic [req_id_width_p-1:0]  grant_id;
    logic [req_id_width_p-1:0]  scan_id;
    logic [req_id_width_p-1:0]  rr_ptr_next;
    logic                       owner_yumi;
    logic                       resp_ready;
    logic                       tag_push;
    logic                       tag_pop;

    for (genvar i = 0; i < num_req_p; i++) begin : g_unpack
        assign req_cmd_arr[i] = req_cmd_i[i*mem_msg_width_p +: mem_msg_width_p];
    end

    always_comb begin
        tag_full   = (tag_cnt_r == max_cnt_lp);
        tag_empty  = (tag_cnt_r == '0);
        // Full is sampled before any same-cycle pop, so a freed slot is only usable
        // next cycle. Reset also blocks grants so no ready bit rises while held.
        can_accept = (~cmd_v_r | mem_cmd_yumi_i) & ~tag_full & ~reset_i;
    end

    // Round-robin scan starting at rr_ptr_r, wrapping modulo num_req_p.
    always_comb begin
        grant_v  = 1'b0;
        grant_id = '0;
        scan_id  = rr_ptr_r;
        for (int unsigned k = 0; k < num_req_p; k++) begin
            if (!grant_v && req_cmd_v_i[scan_id]) begin
                grant_v  = 1'b1;
                grant_id = scan_id;
            end
            scan_id = (scan_id == last_id_lp) ? '0 : scan_id + req_id_width_p'(1);
        end
        grant_v = grant_v & can_accept;
    end

    always_comb begin
        rr_ptr_next = (grant_id == last_id_lp) ? '0 : grant_id + req_id_width_p'(1);
    end

    always_comb begin
        owner_yumi = req_resp_yumi_i[resp_id_r];
        resp_ready = ~tag_empty & (~resp_v_r | owner_yumi);
        tag_push   = grant_v;
        tag_pop    = mem_resp_v_i & resp_ready;
    end

    // ------------------------------------------------------------------
    // Command stage
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cmd_v_r   <= 1'b0;
            mem_cmd_r <= '0;
            rr_ptr_r  <= '0;
        end else begin
            if (grant_v) begin
                cmd_v_r   <= 1'b1;
                mem_cmd_r <= req_cmd_arr[grant_id];
                rr_ptr_r  <= rr_ptr_next;
            end else if (mem_cmd_yumi_i) begin
                cmd_v_r <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Tag FIFO
    // ------------------------------------------------------------------
    // Storage needs no reset: entries are only read while the count says they are live.
    always_ff @(posedge clk_i) begin
        if (tag_push) begin
            tag_mem_r[tag_wr_ptr_r] <= grant_id;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            tag_rd_ptr_r <= '0;
            tag_wr_ptr_r <= '0;
            tag_cnt_r    <= '0;
        end else begin
            if (tag_push) begin
                tag_wr_ptr_r <= (tag_wr_ptr_r == last_ptr_lp) ? '0
                                                              : tag_wr_ptr_r + ptr_width_lp'(1);
            end
            if (tag_pop) begin
                tag_rd_ptr_r <= (tag_rd_ptr_r == last_ptr_lp) ? '0
                                                              : tag_rd_ptr_r + ptr_width_lp'(1);
            end
            case ({tag_push, tag_pop})
                2'b10:   tag_cnt_r <= tag_cnt_r + cnt_width_lp'(1);
                2'b01:   tag_cnt_r <= tag_cnt_r - cnt_width_lp'(1);
                default: tag_cnt_r <= tag_cnt_r;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Response buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            resp_v_r  <= 1'b0;
            resp_id_r <= '0;
            resp_r    <= '0;
        end else begin
            if (tag_pop) begin
                resp_v_r  <= 1'b1;
                resp_id_r <= tag_mem_r[tag_rd_ptr_r];
                resp_r    <= mem_resp_i;
            end else if (resp_v_r && owner_yumi) begin
                resp_v_r <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        req_cmd_ready_o  = grant_v ? (num_req_p'(1) << grant_id) : '0;
        mem_cmd_o        = mem_cmd_r;
        mem_cmd_v_o      = cmd_v_r;
        mem_resp_ready_o = resp_ready;
        req_resp_o       = resp_r;
        req_resp_v_o     = resp_v_r ? (num_req_p'(1) << resp_id_r) : '0;
        outstanding_o    = tag_cnt_r;
    end

`ifndef SYNTHESIS
    // Protocol checks on the surrounding agents.
    a_resp_without_tag : assert property (@(posedge clk_i) disable iff (reset_i)
        !(mem_resp_v_i && tag_empty))
        else $error("mem_resp_v_i asserted with no outstanding command");

    a_resp_yumi_without_v : assert property (@(posedge clk_i) disable iff (reset_i)
        ((req_resp_yumi_i & ~req_resp_v_o) == '0))
        else $error("req_resp_yumi_i asserted on a requester without valid");

    a_cmd_yumi_without_v : assert property (@(posedge clk_i) disable iff (reset_i)
        !(mem_cmd_yumi_i && !cmd_v_r))
        else $error("mem_cmd_yumi_i asserted without mem_cmd_v_o");
`endif

endmodule

// File: doc/bp_mem_cmd_arbiter.md
Name: bp_mem_cmd_arbiter

Overview:
- Shares one backing-memory command/response port (e.g. bp_mem, or the host I/O path) between num_req_p memory-message requesters, such as a core's mem port and a DMA or I/O agent.
- Arbitrates commands round-robin into a one-entry registered output stage.
- Records the granted requester ID in an in-order tag FIFO.
- Steers each returning response back to its originator through a one-entry response buffer.
- Sits between the requesters' bsg_two_fifo outputs and the memory model.

Parameters:
- num_req_p, 2: number of requesters (2..8).
- mem_msg_width_p, 128: width of a bp_cce_mem_msg_s (packed).
- max_outstanding_p, 4: tag FIFO depth, i.e. maximum commands issued without a response (power of 2).
- req_id_width_p, `BSG_SAFE_CLOG2(num_req_p)`: requester ID width.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  asynchronous, active-high reset.
- req_cmd_i  in  num_req_p*mem_msg_width_p  per-requester command, requester i at slice i.
- req_cmd_v_i  in  num_req_p  command valid.
- req_cmd_ready_o  out  num_req_p  command accepted this cycle (ready&valid handshake).
- mem_cmd_o  out  mem_msg_width_p  command to memory.
- mem_cmd_v_o  out  1  command valid.
- mem_cmd_yumi_i  in  1  memory consumed mem_cmd_o.
- mem_resp_i  in  mem_msg_width_p  response from memory.
- mem_resp_v_i  in  1  response valid.
- mem_resp_ready_o  out  1  arbiter can take a response.
- req_resp_o  out  mem_msg_width_p  response data, broadcast to all requesters.
- req_resp_v_o  out  num_req_p  one-hot valid to the owning requester.
- req_resp_yumi_i  in  num_req_p  requester consumed the response.
- outstanding_o  out  `BSG_WIDTH(max_outstanding_p)`  commands issued with no response yet buffered.

Behaviour:
- Reset (async assert, sync deassert by the system):
  - cmd_v_r=0, resp_v_r=0, tag FIFO empty, rr_ptr=0.
  - All req_cmd_ready_o=0, mem_cmd_v_o=0, req_resp_v_o=0, outstanding_o=0.
  - mem_resp_ready_o=1 is not allowed while the tag FIFO is empty (see below), so it reads 0 after reset.
  - Reset mid-transaction discards all held commands, responses and tags; no outputs glitch high.
- Command-accept condition: can_accept = (~cmd_v_r | mem_cmd_yumi_i) & ~tag_full.
- Grant:
  - Round-robin over req_cmd_v_i, starting at rr_ptr and wrapping modulo num_req_p.
  - At most one req_cmd_ready_o bit is high, and only when can_accept is true.
  - On grant to requester g: mem_cmd_r<=req_cmd_i[g], cmd_v_r<=1, push g into tag FIFO, rr_ptr<=(g+1) mod num_req_p.
  - With no grant, rr_ptr is held.
  - A requester continuously valid is granted at least once every num_req_p grants.
- Command latency: exactly 1 cycle from acceptance to mem_cmd_v_o. mem_cmd_o=mem_cmd_r.
  - On yumi with no new grant, cmd_v_r<=0.
  - Yumi and grant in the same cycle gives back-to-back issue at 1 command/cycle.
- Tag FIFO:
  - Pushed on grant, popped when a response enters the response buffer.
  - Push and pop in the same cycle are legal, including when the FIFO is full (pop frees space; can_accept uses full before pop, so no grant that cycle).
- Response path:
  - mem_resp_ready_o = ~tag_empty & (~resp_v_r | req_resp_yumi_i[resp_id_r]).
  - On mem_resp_v_i & mem_resp_ready_o: resp_r<=mem_resp_i, resp_id_r<=tag head, resp_v_r<=1, pop tag.
  - req_resp_o=resp_r; req_resp_v_o = resp_v_r ? (1<<resp_id_r) : 0.
  - On yumi of the owner with no new response, resp_v_r<=0.
  - Yumi and a new response in the same cycle sustain 1 response/cycle.
  - A response is delivered 1 cycle after memory handshake.
- Ordering: responses are assumed in command order (the memory is in-order); steering is strictly FIFO.
- outstanding_o: increments on grant, decrements on tag pop, and is unchanged when both occur. Range is 0..max_outstanding_p.
- Assertions (nonsynth):
  - mem_resp_v_i while tag FIFO empty is an error; the response is not accepted.
  - req_resp_yumi_i set on a bit without valid is an error.
  - mem_cmd_yumi_i without mem_cmd_v_o is an error.

Test Plan:
- Single requester: req0 sends 3 commands with yumi always 1 and memory latency 5 → mem_cmd_v_o high cycles 1,2,3 after the respective accepts; 3 responses returned with req_resp_v_o=01 each; outstanding_o peaks at 3 and returns to 0.
- Fairness: both requesters continuously valid, 8 grants → grant order 0,1,0,1,0,1,0,1; each response steered to the matching ID in order.
- Backpressure/full: max_outstanding_p=4, memory withholds responses → exactly 4 grants, then req_cmd_ready_o=00 while valid held; the first response re-enables exactly one grant.
- Response stall: requester 1 holds yumi low for 10 cycles → mem_resp_ready_o=0 for those cycles, no response lost; yumi and a new response in the same cycle yield 1 response/cycle.
- Simultaneous: tag full, response pop and pending valid in the same cycle → no grant that cycle; grant occurs next cycle; outstanding_o goes 4→3→4.
- Async reset asserted mid-burst with 2 outstanding and cmd_v_r=1 → all valids drop immediately, outstanding_o=0; after release, a fresh command from req1 is granted first at rr_ptr=0 order (req0 idle).
